board_keeper: RTL

Board-state owner and move sequencer for the 16x16 five-in-a-row game. It sits directly upstream of the win-checker chain (horizontal, vertical, two diagonals). It holds the 256-cell board and accepts a placement at the cursor address. It commits the stone for the side to move, launches the checker chain, serves the chain's cell reads, and records the game result.

---
 rtl/gomoku_pkg.sv | 29 ++
 rtl/board_store.sv | 32 +++
 rtl/board_keeper.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gomoku_pkg.sv
// Shared types for the five-in-a-row board: cell encoding, board_keeper states,
// board geometry and cell address type.
package gomoku_pkg;

    localparam int unsigned BOARD_DIM  = 16;
    localparam int unsigned CELL_COUNT = BOARD_DIM * BOARD_DIM;

    typedef logic [7:0] addr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BLACK = 2'd1,
        WHITE = 2'd2,
        RSVD  = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CHECK,
        OVER,
        CLEAR
    } bk_state_t;

    function automatic cell_t other_side(input cell_t c);
        return (c == BLACK) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/board_store.sv
// 256 x 2-bit board flop array: one synchronous write port, a combinational
// checker read port, a combinational occupancy read, async active-low clear.
module board_store
    import gomoku_pkg::*;
(
    input  logic  clk,
    input  logic  rst_ni,
    input  logic  we_i,
    input  addr_t wr_addr_i,
    input  cell_t wr_data_i,
    input  addr_t rd_addr_i,
    output cell_t rd_data_o,
    input  addr_t occ_addr_i,
    output logic  occupied_o
);

    cell_t cells_q [CELL_COUNT];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < CELL_COUNT; i++) begin
                cells_q[i] <= EMPTY;
            end
        end else if (we_i) begin
            cells_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o  = cells_q[rd_addr_i];
    assign occupied_o = (cells_q[occ_addr_i] != EMPTY);

endmodule

// File: rtl/board_keeper.sv
// Board owner and move sequencer feeding the win-checker chain.
// Optional one-level undo is enabled by defining BOARD_UNDO_EN.
module board_keeper
    import gomoku_pkg::*;
#(
    parameter int unsigned CHECK_TIMEOUT = 1023,
    parameter int unsigned ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              place,
    input  logic [ADDR_W-1:0] pointer,
    input  logic              new_game,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_state,
    output logic [1:0]        chess,
    output logic              active,
    input  logic              chain_done,
    input  logic              success,
`ifdef BOARD_UNDO_EN
    input  logic              undo,
`endif
    output logic              place_ack,
    output logic              place_nack,
    output logic [1:0]        turn,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              busy,
    output logic              chk_err
);

    localparam int unsigned TW = $clog2(CHECK_TIMEOUT + 1);

    bk_state_t      state_q, state_d;
    cell_t          turn_q, turn_d;
    cell_t          chess_q, chess_d;
    cell_t          winner_q, winner_d;
    logic [8:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    addr_t          clr_q, clr_d;
    logic           over_q, over_d;
    logic           err_q, err_d;
    logic           ack_q, ack_d;
    logic           nack_q, nack_d;
    logic           act_q, act_d;
`ifdef BOARD_UNDO_EN
    addr_t          last_q, last_d;
    logic           vld_q, vld_d;
`endif

    logic  wr_en;
    addr_t wr_addr;
    cell_t wr_data;
    cell_t rd_cell;
    logic  occ;
    logic  req;
    logic  timed_out;
    logic  done;

`ifdef BOARD_UNDO_EN
    assign req = place | undo;
`else
    assign req = place;
`endif

    board_store u_store (
        .clk        (clk),
        .rst_ni     (reset),
        .we_i       (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_cell),
        .occ_addr_i (pointer),
        .occupied_o (occ)
    );

    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        chess_d   = chess_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        clr_d     = clr_q;
        over_d    = over_q;
        err_d     = err_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = pointer;
        wr_data   = turn_q;
        timed_out = 1'b0;
        done      = 1'b0;
`ifdef BOARD_UNDO_EN
        last_d    = last_q;
        vld_d     = vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (new_game) begin
                    nack_d  = req;
                    clr_d   = '0;
                    state_d = CLEAR;
                end else if (place) begin
                    if (occ) begin
                        nack_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = WRITE;
`ifdef BOARD_UNDO_EN
                        last_d  = pointer;
                        vld_d   = 1'b1;
`endif
                    end
                end
`ifdef BOARD_UNDO_EN
                else if (undo) begin
                    if (cnt_q != '0 && vld_q) begin
                        wr_en   = 1'b1;
                        wr_addr = last_q;
                        wr_data = EMPTY;
                        turn_d  = other_side(turn_q);
                        cnt_d   = cnt_q - 9'd1;
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                    end else begin
                        nack_d = 1'b1;
                    end
                end
`endif
            end
            WRITE: begin
                nack_d  = req;
                chess_d = turn_q;
                tmo_d   = '0;
                state_d = CHECK;
            end
            CHECK: begin
                nack_d    = req;
                timed_out = (tmo_q == TW'(CHECK_TIMEOUT));
                if (!timed_out) tmo_d = tmo_q + TW'(1);
                // Checker responses only count once active has actually been seen high.
                done = act_q & chain_done;
                if (act_q && success) begin
                    winner_d = chess_q;
                    over_d   = 1'b1;
                    state_d  = OVER;
                end else if (done || timed_out) begin
                    if (!done) err_d = 1'b1;
                    turn_d = other_side(turn_q);
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q == 9'd255) begin
                        winner_d = EMPTY;
                        over_d   = 1'b1;
                        state_d  = OVER;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OVER: begin
                nack_d = req;
                if (new_game) begin
                    clr_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                nack_d  = req;
                wr_en   = 1'b1;
                wr_addr = clr_q;
                wr_data = EMPTY;
                clr_d   = clr_q + 8'd1;
                if (clr_q == 8'hFF) begin
                    turn_d   = BLACK;
                    cnt_d    = '0;
                    winner_d = EMPTY;
                    over_d   = 1'b0;
                    state_d  = IDLE;
`ifdef BOARD_UNDO_EN
                    vld_d    = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Delayed by one cycle after entering CHECK so chess is stable at the rise.
        act_d = (state_q == CHECK) && (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            turn_q   <= BLACK;
            chess_q  <= EMPTY;
            winner_q <= EMPTY;
            cnt_q    <= '0;
            tmo_q    <= '0;
            clr_q    <= '0;
            over_q   <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            act_q    <= 1'b0;
`ifdef BOARD_UNDO_EN
            last_q   <= '0;
            vld_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            chess_q  <= chess_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            clr_q    <= clr_d;
            over_q   <= over_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            act_q    <= act_d;
`ifdef BOARD_UNDO_EN
            last_q   <= last_d;
            vld_q    <= vld_d;
`endif
        end
    end

    assign rd_state   = rd_cell;
    assign chess      = chess_q;
    assign active     = act_q;
    assign place_ack  = ack_q;
    assign place_nack = nack_q;
    assign turn       = turn_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign busy       = (state_q != IDLE) && (state_q != OVER);
    assign chk_err    = err_q;

endmodule
